vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 161 ++++++++++++++++
 tb/tb_vend_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Coin-operated vending controller: credit accumulation, item dispense with
// timed motor pulse, change return and cancel refund. All outputs registered.
`timescale 1ns/1ps
module vend_controller #(
    parameter logic [7:0] PRICE0      = 8'd25,
    parameter logic [7:0] PRICE1      = 8'd50,
    parameter logic [7:0] PRICE2      = 8'd75,
    parameter logic [7:0] PRICE3      = 8'd100,
    parameter logic [7:0] MAX_CREDIT  = 8'd200,
    parameter logic [2:0] DISP_CYCLES = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_reject,
    output logic       low_credit,
    output logic       busy
);

    localparam int unsigned CW = 8;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE,
        S_REFUND
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] credit_n, price_q, price_n, sel_price, coin_amt, change_amt_n;
    logic [SW-1:0] coin_sum;
    logic [2:0]    cnt, cnt_n;
    logic [1:0]    item_n;
    logic          dispense_n, change_valid_n, coin_reject_n, low_credit_n, busy_n;

    // Price and coin decode
    always_comb begin
        case (sel_item)
            2'd0:    sel_price = PRICE0;
            2'd1:    sel_price = PRICE1;
            2'd2:    sel_price = PRICE2;
            default: sel_price = PRICE3;
        endcase
        case (coin_value)
            2'd0:    coin_amt = CW'(5);
            2'd1:    coin_amt = CW'(10);
            2'd2:    coin_amt = CW'(25);
            default: coin_amt = CW'(100);
        endcase
        coin_sum = SW'(credit) + SW'(coin_amt);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        credit_n       = credit;
        price_n        = price_q;
        cnt_n          = cnt;
        item_n         = item_out;
        dispense_n     = 1'b0;
        change_valid_n = 1'b0;
        change_amt_n   = '0;
        coin_reject_n  = 1'b0;
        low_credit_n   = 1'b0;

        case (state)
            S_IDLE, S_COLLECT: begin
                // Cancel only means something once credit has been collected
                if (cancel && state == S_COLLECT) begin
                    state_n        = S_REFUND;
                    change_valid_n = 1'b1;
                    change_amt_n   = credit;
                end else if (sel_valid) begin
                    if (credit >= sel_price) begin
                        state_n    = S_DISPENSE;
                        dispense_n = 1'b1;
                        item_n     = sel_item;
                        cnt_n      = DISP_CYCLES;
                        price_n    = sel_price;
                    end else begin
                        low_credit_n = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum > SW'(MAX_CREDIT)) begin
                        coin_reject_n = 1'b1;
                    end else begin
                        credit_n = coin_sum[CW-1:0];
                        state_n  = S_COLLECT;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_n = coin_valid;
                if (cnt <= 3'd1) begin
                    state_n        = S_CHANGE;
                    item_n         = 2'd0;
                    cnt_n          = 3'd0;
                    change_amt_n   = credit - price_q;
                    change_valid_n = (credit != price_q);
                end else begin
                    cnt_n      = cnt - 3'd1;
                    dispense_n = 1'b1;
                end
            end
            S_CHANGE, S_REFUND: begin
                coin_reject_n = coin_valid;
                credit_n      = '0;
                state_n       = S_IDLE;
            end
            default: begin
                state_n  = S_IDLE;
                credit_n = '0;
                item_n   = 2'd0;
                cnt_n    = 3'd0;
            end
        endcase

        busy_n = (state_n == S_DISPENSE) || (state_n == S_CHANGE) || (state_n == S_REFUND);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            price_q      <= '0;
            cnt          <= 3'd0;
            item_out     <= 2'd0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            low_credit   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            price_q      <= price_n;
            cnt          <= cnt_n;
            item_out     <= item_n;
            dispense     <= dispense_n;
            change_valid <= change_valid_n;
            change_amt   <= change_amt_n;
            coin_reject  <= coin_reject_n;
            low_credit   <= low_credit_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus random strobes, checked
// against a transaction-level model that schedules future output cycles.
`timescale 1ns/1ps
module tb_vend_controller;

    localparam int DISP = 4;
    localparam int MAXC = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid, sel_valid, cancel;
    logic [1:0] coin_value, sel_item;
    logic [7:0] credit, change_amt;
    logic [1:0] item_out;
    logic       dispense, change_valid, coin_reject, low_credit, busy;

    vend_controller dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .credit(credit), .dispense(dispense), .item_out(item_out),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .low_credit(low_credit), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // One scheduled output cycle of the model
    typedef struct packed {
        logic       busy;
        logic       disp;
        logic [1:0] item;
        logic       cv;
        logic [7:0] amt;
        logic       clear;
    } slot_t;

    int    prices[4] = '{25, 50, 75, 100};
    int    coins[4]  = '{5, 10, 25, 100};
    slot_t cur;
    slot_t sched[$];
    int    m_credit;
    logic  m_rej, m_low;

    task automatic model_reset();
        m_credit = 0;
        m_rej    = 1'b0;
        m_low    = 1'b0;
        cur      = '0;
        sched.delete();
    endtask

    // Machine behaviour at one rising edge, from the sampled inputs
    task automatic model_edge();
        slot_t s;
        int    chg;
        m_rej = 1'b0;
        m_low = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (cur.busy) begin
            m_rej = coin_valid;
            if (cur.clear) m_credit = 0;
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = '0;
        end else if (cancel && m_credit > 0) begin
            s = '0; s.busy = 1'b1; s.cv = 1'b1; s.amt = 8'(m_credit); s.clear = 1'b1;
            cur = s;
        end else if (sel_valid) begin
            if (m_credit >= prices[sel_item]) begin
                for (int i = 0; i < DISP; i++) begin
                    s = '0; s.busy = 1'b1; s.disp = 1'b1; s.item = sel_item;
                    sched.push_back(s);
                end
                chg = m_credit - prices[sel_item];
                s = '0; s.busy = 1'b1; s.cv = (chg != 0); s.amt = 8'(chg); s.clear = 1'b1;
                sched.push_back(s);
                cur = sched.pop_front();
            end else begin
                m_low = 1'b1;
            end
        end else if (coin_valid) begin
            if (m_credit + coins[coin_value] > MAXC) m_rej = 1'b1;
            else m_credit = m_credit + coins[coin_value];
        end
    endtask

    task automatic check_all();
        check_val("credit",       32'(credit),       32'(m_credit));
        check_val("dispense",     32'(dispense),     32'(cur.disp));
        check_val("item_out",     32'(item_out),     32'(cur.item));
        check_val("change_valid", 32'(change_valid), 32'(cur.cv));
        check_val("change_amt",   32'(change_amt),   32'(cur.amt));
        check_val("coin_reject",  32'(coin_reject),  32'(m_rej));
        check_val("low_credit",   32'(low_credit),   32'(m_low));
        check_val("busy",         32'(busy),         32'(cur.busy));
    endtask

    // Drive one cycle of inputs, then update model and compare after the edge
    task automatic cycle(input logic cv, input logic [1:0] cval, input logic sv,
                         input logic [1:0] si, input logic cn);
        coin_valid = cv; coin_value = cval; sel_valid = sv; sel_item = si; cancel = cn;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic coin(input logic [1:0] v);
        cycle(1'b1, v, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic sel(input logic [1:0] it);
        cycle(1'b0, 2'd0, 1'b1, it, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic async_reset();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("rst_dispense", 32'(dispense), 32'd0);
        check_val("rst_credit",   32'(credit),   32'd0);
        check_val("rst_busy",     32'(busy),     32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        coin_valid = 1'b0; coin_value = 2'd0; sel_valid = 1'b0; sel_item = 2'd0; cancel = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // 25+25, buy item 1: exact credit, no change
        coin(2'd2); coin(2'd2); sel(2'd1); idle(DISP + 3);

        // 100+10, buy item 0: change 85
        coin(2'd3); coin(2'd1); sel(2'd0); idle(DISP + 3);

        // Fill to ceiling, then overflow by 5
        coin(2'd3); coin(2'd3);
        check_val("ceiling", 32'(credit), 32'd200);
        coin(2'd0);
        check_val("over_ceiling", 32'(credit), 32'd200);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1); idle(2);

        // Insufficient credit, then cancel refunds 10
        coin(2'd1); sel(2'd3); idle(1);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1); idle(2);

        // Coin, sel, cancel coincident: cancel wins
        coin(2'd2); cycle(1'b1, 2'd2, 1'b1, 2'd0, 1'b1); idle(2);

        // Coin while dispensing is rejected
        coin(2'd3); sel(2'd2); coin(2'd1); coin(2'd0); idle(DISP + 2);

        // Cancel in IDLE is ignored; coincident coin still counts
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b1); cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b1); idle(2);

        // Reset during second dispense cycle
        coin(2'd2); coin(2'd2); sel(2'd1); idle(1);
        async_reset();
        coin(2'd0);
        check_val("post_reset_coin", 32'(credit), 32'd5);
        idle(2);

        // Random strobes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            cycle(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
